// File: rtl/seq_mul_div_if.sv
// seq_mul_div_if: start/busy/done handshake and operand/result bus of the multiply/divide unit
interface seq_mul_div_if #(parameter int N = 16);
  logic         start;
  logic         op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] result_lo;
  logic [N-1:0] result_hi;
  logic         div_by_zero;
  modport master (output start, op, a, b, input busy, done, result_lo, result_hi, div_by_zero);
  modport slave  (input start, op, a, b, output busy, done, result_lo, result_hi, div_by_zero);
endinterface

// File: rtl/seq_mul_div.sv
// seq_mul_div: one-bit-per-clock unsigned shift-add multiplier / restoring divider
module seq_mul_div #(parameter int N = 16) (
  input logic         clk,
  input logic         rst_b,
  seq_mul_div_if.slave bus
);
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic is_div, accept, dz, last;
  logic [N-1:0] opd, acc_hi, acc_lo, nhi, nlo;
  logic [N:0] sum, s, trial, diff;
  assign accept = bus.start && state != RUN;
  assign dz = accept && bus.op && bus.b == '0;
  assign last = state == RUN && cnt == '0;
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) state <= IDLE;
    else state <= state_nx;
  always_comb state_nx = accept ? (dz ? DONE : RUN) : last ? DONE : state == RUN ? RUN : IDLE;
  always_comb begin
    bus.busy = state == RUN;
    bus.done = state == DONE;
  end
  // acc_hi is the product high half / remainder, acc_lo the multiplier / quotient
  always_comb begin
    sum = {1'b0, acc_hi} + {1'b0, opd};
    s = acc_lo[0] ? sum : {1'b0, acc_hi};
    trial = {acc_hi, acc_lo[N-1]};
    diff = trial - {1'b0, opd};
    nhi = is_div ? (diff[N] ? trial[N-1:0] : diff[N-1:0]) : s[N:1];
    nlo = is_div ? {acc_lo[N-2:0], ~diff[N]} : {s[0], acc_lo[N-1:1]};
  end
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      cnt <= '0;
      is_div <= 1'b0;
      opd <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
    end else if (accept) begin
      cnt <= CW'(N - 1);
      is_div <= bus.op;
      opd <= bus.op ? bus.b : bus.a;
      acc_hi <= '0;
      acc_lo <= bus.op ? bus.a : bus.b;
    end else if (state == RUN) begin
      cnt <= cnt - CW'(1);
      acc_hi <= nhi;
      acc_lo <= nlo;
    end
  // results are loaded only on entry to DONE so the previous ones stay visible during RUN
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      bus.result_lo <= '0;
      bus.result_hi <= '0;
      bus.div_by_zero <= 1'b0;
    end else if (dz) begin
      bus.result_lo <= '1;
      bus.result_hi <= bus.a;
      bus.div_by_zero <= 1'b1;
    end else if (last) begin
      bus.result_lo <= nlo;
      bus.result_hi <= nhi;
      bus.div_by_zero <= 1'b0;
    end
endmodule
